rsa_cmd_responder: RTL and testbench
====================================

// Module: rsa_cmd_responder
// PURPOSE
//  FPGA-side responder for the ARM<->FPGA command/data protocol of the RSA accelerator.
//  Decodes 32-bit commands, sinks five 1024-bit operands, starts the exponentiation core,
//  and returns its result. Signals completion with a done flag that stays high until the
//  ARM acknowledges it. Sits between the ARM-facing wrapper ports and the RSA core.
// PARAMETERS
//  DATA_W    1024  width of data words, operands and result
//  CMD_W     32    width of the command word
//  NUM_OPS   5     operand slots: 0=msg 1=exp 2=n 3=rmodn 4=r2modn
// PORTS
//  clk                     in   1       system clock; all logic on rising edge
//  reset                   in   1       synchronous, active-high reset
//  arm_to_fpga_cmd         in   CMD_W   command: 0=READ, 1=COMPUTE, 2=WRITE
//  arm_to_fpga_cmd_valid   in   1       command qualifier; sampled only in IDLE
//  fpga_to_arm_done        out  1       operation complete; held until done_read
//  fpga_to_arm_done_read   in   1       ARM acknowledges done
//  arm_to_fpga_data_valid  in   1       inbound data word valid
//  arm_to_fpga_data_ready  out  1       responder can accept inbound word
//  arm_to_fpga_data        in   DATA_W  inbound data word
//  fpga_to_arm_data_valid  out  1       outbound result valid
//  fpga_to_arm_data_ready  in   1       ARM can accept outbound word
//  fpga_to_arm_data        out  DATA_W  outbound data; equals result register
//  core_start              out  1       one-cycle start pulse to RSA core
//  core_done               in   1       RSA core finished; core_result valid this cycle
//  core_result             in   DATA_W  RSA core result
//  op_msg, op_exp, op_n    out  DATA_W  operand registers 0..2
//  op_rmodn, op_r2modn     out  DATA_W  operand registers 3..4
//  leds                    out  4       {error, state[2:0]}
// BEHAVIOUR
//  States: IDLE(0) RX(1) START(2) WAIT_CORE(3) TX(4) DONE(5). Outputs decode from registers.
//  Reset:
//   - state=IDLE; slot index=0; operand and result registers=0; error=0.
//   - All outputs 0.
//  IDLE: on cmd_valid, next state from cmd (t+1):
//   - READ -> RX; COMPUTE -> START; WRITE -> TX.
//   - Any other value -> DONE with error=1.
//   - Without cmd_valid, stay in IDLE. Error clears on the next valid command.
//  RX:
//   - data_ready=1.
//   - On an edge with data_valid&&data_ready: data -> operand[idx].
//   - idx increments and wraps NUM_OPS-1 -> 0; then go to DONE.
//   - data_valid outside RX is ignored.
//  START:
//   - core_start=1 for exactly one cycle; idx resets to 0; then go to WAIT_CORE.
//  WAIT_CORE:
//   - Stay until core_done=1; on that edge core_result -> result register; then go to DONE.
//   - core_done outside WAIT_CORE is ignored.
//  TX:
//   - data_valid=1; fpga_to_arm_data=result.
//   - On an edge with valid&&ready, go to DONE.
//   - The result register is unchanged by TX, so repeated WRITEs return the same value.
//  DONE:
//   - done=1. On done_read=1, go to IDLE the next cycle.
//   - done_read in any other state is ignored.
//  cmd_valid outside IDLE: ignored, not queued.
//  Minimum latencies:
//   - READ: done at cmd+2 cycles.
//   - COMPUTE: done the cycle after core_done.
//   - WRITE: done at cmd+2 cycles.
//  Synchronous reset mid-operation:
//   - Aborts immediately to the reset state; operands are lost.
//   - core_start is not reissued.
// TESTING
//  1. Reset check: reset=1 for 3 cycles
//     -> all outputs 0, leds=4'h0.
//  2. Five READs: send 5'h11..5'h15, each acked via done_read
//     -> op_msg=0x11 ... op_r2modn=0x15.
//     A sixth READ of 0x99 overwrites op_msg (index wrap).
//  3. COMPUTE: core model raises core_done 10 cycles after core_start with result 0xABCD
//     -> core_start high for exactly 1 cycle; done high the cycle after core_done.
//  4. WRITE after COMPUTE: ARM ready held low for 4 cycles, then high
//     -> data_valid stays high with data 0xABCD; done asserted 1 cycle after the handshake.
//     A second WRITE returns 0xABCD again.
//  5. Command 32'h7
//     -> done at t+1, leds[3]=1, no ready/valid/start activity.
//     A following READ clears leds[3].
//  6. Protocol abuse:
//     - cmd_valid pulsed while in WAIT_CORE -> ignored; done only after core_done.
//     - reset asserted in RX with data_valid=1 -> operand not written; idx=0.

Source files
------------

// File: rtl/rsa_cmd_responder.sv
// rsa_cmd_responder
// FPGA-side endpoint of the ARM<->FPGA command/data protocol for the RSA
// accelerator. Decodes READ / COMPUTE / WRITE commands, collects the five
// operands in round-robin order, kicks the exponentiation core, captures its
// result and returns it. Every operation ends in DONE, which is held until the
// ARM acknowledges it with done_read.
module rsa_cmd_responder #(
    parameter int DATA_W  = 1024,
    parameter int CMD_W   = 32,
    parameter int NUM_OPS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [DATA_W-1:0] op_msg,
    output logic [DATA_W-1:0] op_exp,
    output logic [DATA_W-1:0] op_n,
    output logic [DATA_W-1:0] op_rmodn,
    output logic [DATA_W-1:0] op_r2modn,
    output logic [3:0]        leds
);

    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

    localparam logic [CMD_W-1:0] CMD_READ    = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_COMPUTE = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(2);

    // Encoding is visible on leds[2:0], so the values are fixed.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RX        = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_TX        = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ops_q [NUM_OPS];
    logic [DATA_W-1:0] result_q;

    logic rx_fire;
    logic core_fire;

    // Inbound word is taken only while RX is advertising ready; core_done only
    // counts while we are actually waiting for the core.
    assign rx_fire   = (state_q == S_RX) && arm_to_fpga_data_valid;
    assign core_fire = (state_q == S_WAIT_CORE) && core_done;

    // Control registers: state, operand slot index, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; commands are only looked at in IDLE and are never queued.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    err_d = 1'b0;
                    if (arm_to_fpga_cmd == CMD_READ) begin
                        state_d = S_RX;
                    end else if (arm_to_fpga_cmd == CMD_COMPUTE) begin
                        state_d = S_START;
                    end else if (arm_to_fpga_cmd == CMD_WRITE) begin
                        state_d = S_TX;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RX: begin
                if (rx_fire) begin
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    state_d = S_DONE;
                end
            end
            S_START: begin
                // A new operand load after a compute starts again at msg.
                idx_d   = '0;
                state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    state_d = S_DONE;
                end
            end
            S_TX: begin
                if (fpga_to_arm_data_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (fpga_to_arm_done_read) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand slots: the current slot index selects which register captures the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (rx_fire && (idx_q == IDX_W'(i))) begin
                    ops_q[i] <= arm_to_fpga_data;
                end
            end
        end
    end

    // Result register: written only by the core, so repeated WRITEs return the same value.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (core_fire) begin
            result_q <= core_result;
        end
    end

    assign fpga_to_arm_done       = (state_q == S_DONE);
    assign arm_to_fpga_data_ready = (state_q == S_RX);
    assign fpga_to_arm_data_valid = (state_q == S_TX);
    assign core_start             = (state_q == S_START);
    assign fpga_to_arm_data       = result_q;
    assign leds                   = {err_q, state_q};

    assign op_msg    = ops_q[0];
    assign op_exp    = ops_q[1];
    assign op_n      = ops_q[2];
    assign op_rmodn  = ops_q[3];
    assign op_r2modn = ops_q[4];

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Testbench for rsa_cmd_responder: scenario tasks drive the ARM and core sides
// and compare against a transaction-level model of operands/result/slot index.
module tb_rsa_cmd_responder;

    localparam int DATA_W  = 1024;
    localparam int CMD_W   = 32;
    localparam int NUM_OPS = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [CMD_W-1:0]  arm_to_fpga_cmd;
    logic              arm_to_fpga_cmd_valid;
    logic              fpga_to_arm_done;
    logic              fpga_to_arm_done_read;
    logic              arm_to_fpga_data_valid;
    logic              arm_to_fpga_data_ready;
    logic [DATA_W-1:0] arm_to_fpga_data;
    logic              fpga_to_arm_data_valid;
    logic              fpga_to_arm_data_ready;
    logic [DATA_W-1:0] fpga_to_arm_data;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_result;
    logic [DATA_W-1:0] op_msg, op_exp, op_n, op_rmodn, op_r2modn;
    logic [3:0]        leds;

    logic [DATA_W-1:0] dut_ops [NUM_OPS];
    assign dut_ops[0] = op_msg;
    assign dut_ops[1] = op_exp;
    assign dut_ops[2] = op_n;
    assign dut_ops[3] = op_rmodn;
    assign dut_ops[4] = op_r2modn;

    // Reference model: operand slots, next slot, last core result.
    logic [DATA_W-1:0] m_ops [NUM_OPS];
    int                m_idx;
    logic [DATA_W-1:0] m_result;

    int n_tests = 0;
    int n_fail  = 0;

    rsa_cmd_responder #(.DATA_W(DATA_W), .CMD_W(CMD_W), .NUM_OPS(NUM_OPS)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .core_start             (core_start),
        .core_done              (core_done),
        .core_result            (core_result),
        .op_msg                 (op_msg),
        .op_exp                 (op_exp),
        .op_n                   (op_n),
        .op_rmodn               (op_rmodn),
        .op_r2modn              (op_r2modn),
        .leds                   (leds)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    // Advance one cycle; inputs set afterwards are sampled at the next edge,
    // outputs read afterwards reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [CMD_W-1:0] c);
        arm_to_fpga_cmd       = c;
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = $urandom;
    endtask

    task automatic ack();
        fpga_to_arm_done_read = 1'b1;
        tick();
        fpga_to_arm_done_read = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_OPS; i++) m_ops[i] = '0;
        m_idx    = 0;
        m_result = '0;
    endtask

    task automatic op_read(input logic [DATA_W-1:0] d, input int delay);
        do_cmd(CMD_W'(0));
        n_tests++;
        if ({arm_to_fpga_data_ready, fpga_to_arm_done, leds} !== 6'b10_0001) begin
            n_fail++;
            $display("FAIL read_enter_rx: ready,done,leds=%b required %b",
                     {arm_to_fpga_data_ready, fpga_to_arm_done, leds}, 6'b10_0001);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            n_tests++;
            if ({arm_to_fpga_data_ready, fpga_to_arm_done} !== 2'b10) begin
                n_fail++;
                $display("FAIL read_wait: ready,done=%b required 10",
                         {arm_to_fpga_data_ready, fpga_to_arm_done});
            end
        end
        arm_to_fpga_data       = d;
        arm_to_fpga_data_valid = 1'b1;
        tick();
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = rand_word();
        m_ops[m_idx] = d;
        m_idx        = (m_idx + 1) % NUM_OPS;
        n_tests++;
        if ({arm_to_fpga_data_ready, fpga_to_arm_done, leds} !== 6'b01_0101) begin
            n_fail++;
            $display("FAIL read_done: ready,done,leds=%b required %b",
                     {arm_to_fpga_data_ready, fpga_to_arm_done, leds}, 6'b01_0101);
        end
        ack();
        for (int i = 0; i < NUM_OPS; i++) begin
            n_tests++;
            if (dut_ops[i] !== m_ops[i]) begin
                n_fail++;
                $display("FAIL read_operand[%0d]: got ..%h required ..%h",
                         i, dut_ops[i][127:0], m_ops[i][127:0]);
            end
        end
        n_tests++;
        if ({fpga_to_arm_done, leds} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL read_back_idle: done,leds=%b required 00000", {fpga_to_arm_done, leds});
        end
    endtask

    task automatic op_compute(input logic [DATA_W-1:0] res, input bit abuse);
        do_cmd(CMD_W'(1));
        n_tests++;
        if ({core_start, fpga_to_arm_done, leds} !== 6'b10_0010) begin
            n_fail++;
            $display("FAIL compute_start: start,done,leds=%b required %b",
                     {core_start, fpga_to_arm_done, leds}, 6'b10_0010);
        end
        tick();
        // Core model: core_done follows core_start by 10 cycles.
        for (int c = 1; c < 10; c++) begin
            n_tests++;
            if ({core_start, fpga_to_arm_done, leds} !== 6'b00_0011) begin
                n_fail++;
                $display("FAIL compute_wait[%0d]: start,done,leds=%b required %b",
                         c, {core_start, fpga_to_arm_done, leds}, 6'b00_0011);
            end
            if (abuse && c == 3) begin
                arm_to_fpga_cmd       = CMD_W'(0);
                arm_to_fpga_cmd_valid = 1'b1;
            end
            if (abuse && c == 5) fpga_to_arm_done_read = 1'b1;
            tick();
            arm_to_fpga_cmd_valid = 1'b0;
            fpga_to_arm_done_read = 1'b0;
        end
        n_tests++;
        if ({core_start, fpga_to_arm_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL compute_still_waiting: start,done=%b required 00",
                     {core_start, fpga_to_arm_done});
        end
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done   = 1'b0;
        core_result = rand_word();
        m_result    = res;
        m_idx       = 0;
        n_tests++;
        if ({fpga_to_arm_done, leds} !== 5'b1_0101 || fpga_to_arm_data !== m_result) begin
            n_fail++;
            $display("FAIL compute_done: done,leds=%b data=..%h required 10101 data=..%h",
                     {fpga_to_arm_done, leds}, fpga_to_arm_data[127:0], m_result[127:0]);
        end
        // A stray core_done in DONE must not overwrite the result.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_tests++;
        if (fpga_to_arm_data !== m_result || fpga_to_arm_done !== 1'b1) begin
            n_fail++;
            $display("FAIL compute_stray_core_done: done=%b data=..%h required 1 data=..%h",
                     fpga_to_arm_done, fpga_to_arm_data[127:0], m_result[127:0]);
        end
        ack();
        tick();
        n_tests++;
        if ({core_start, fpga_to_arm_done, arm_to_fpga_data_ready, leds} !== 7'b000_0000) begin
            n_fail++;
            $display("FAIL compute_idle_after: start,done,ready,leds=%b required 0000000",
                     {core_start, fpga_to_arm_done, arm_to_fpga_data_ready, leds});
        end
    endtask

    task automatic op_write(input int hold);
        do_cmd(CMD_W'(2));
        for (int c = 0; c <= hold; c++) begin
            n_tests++;
            if ({fpga_to_arm_data_valid, fpga_to_arm_done, arm_to_fpga_data_ready} !== 3'b100 ||
                fpga_to_arm_data !== m_result) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: valid,done,ready=%b data=..%h required 100 data=..%h",
                         c, {fpga_to_arm_data_valid, fpga_to_arm_done, arm_to_fpga_data_ready},
                         fpga_to_arm_data[127:0], m_result[127:0]);
            end
            if (c < hold) tick();
        end
        fpga_to_arm_data_ready = 1'b1;
        tick();
        fpga_to_arm_data_ready = 1'b0;
        n_tests++;
        if ({fpga_to_arm_done, fpga_to_arm_data_valid, leds} !== 6'b10_0101) begin
            n_fail++;
            $display("FAIL write_done: done,valid,leds=%b required %b",
                     {fpga_to_arm_done, fpga_to_arm_data_valid, leds}, 6'b10_0101);
        end
        ack();
        n_tests++;
        if (fpga_to_arm_data !== m_result || leds !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_result_kept: data=..%h leds=%b required ..%h 0000",
                     fpga_to_arm_data[127:0], leds, m_result[127:0]);
        end
    endtask

    task automatic op_bad(input logic [CMD_W-1:0] c);
        do_cmd(c);
        n_tests++;
        if ({fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid, core_start, leds}
            !== 8'b1000_1101) begin
            n_fail++;
            $display("FAIL bad_cmd_%0h: done,ready,valid,start,leds=%b required 10001101", c,
                     {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid, core_start, leds});
        end
        ack();
        n_tests++;
        if ({fpga_to_arm_done, leds} !== 5'b0_1000) begin
            n_fail++;
            $display("FAIL bad_cmd_idle: done,leds=%b required 01000", {fpga_to_arm_done, leds});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid, core_start, leds}
            !== 8'b0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: done,ready,valid,start,leds=%b required 00000000",
                     {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid, core_start, leds});
        end
        n_tests++;
        if (fpga_to_arm_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got ..%h required 0", fpga_to_arm_data[127:0]);
        end
        for (int i = 0; i < NUM_OPS; i++) begin
            n_tests++;
            if (dut_ops[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_operand[%0d]: got ..%h required 0", i, dut_ops[i][127:0]);
            end
        end
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_reads();
        for (int k = 0; k < NUM_OPS; k++) op_read(DATA_W'(32'h11 + k), 0);
        op_read(DATA_W'(32'h99), 0);
        // data_valid while idle must be ignored.
        arm_to_fpga_data       = rand_word();
        arm_to_fpga_data_valid = 1'b1;
        repeat (2) tick();
        arm_to_fpga_data_valid = 1'b0;
        n_tests++;
        if (op_exp !== m_ops[1] || op_msg !== m_ops[0]) begin
            n_fail++;
            $display("FAIL read_idle_data_ignored: msg=..%h exp=..%h required ..%h ..%h",
                     op_msg[127:0], op_exp[127:0], m_ops[0][127:0], m_ops[1][127:0]);
        end
        for (int k = 0; k < 7; k++) op_read(rand_word(), $urandom_range(0, 3));
    endtask

    task automatic test_compute_write();
        op_compute(DATA_W'(32'hABCD), 1'b0);
        op_write(4);
        op_write(0);
    endtask

    task automatic test_bad_cmd();
        logic [CMD_W-1:0] c;
        op_bad(CMD_W'(7));
        op_read(rand_word(), 0);
        c = $urandom;
        if (c < 3) c = 3;
        op_bad(c);
        op_write(1);
    endtask

    task automatic test_abuse();
        op_compute(rand_word(), 1'b1);
        op_read(rand_word(), 0);
        // Reset while a word is being offered in RX.
        do_cmd(CMD_W'(0));
        arm_to_fpga_data       = rand_word();
        arm_to_fpga_data_valid = 1'b1;
        reset                  = 1'b1;
        tick();
        reset                  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        model_reset();
        n_tests++;
        if ({op_msg, op_exp} !== '0 || {arm_to_fpga_data_ready, leds} !== 5'b0_0000) begin
            n_fail++;
            $display("FAIL reset_in_rx: msg=..%h exp=..%h ready,leds=%b required 0 0 00000",
                     op_msg[127:0], op_exp[127:0], {arm_to_fpga_data_ready, leds});
        end
        op_read(rand_word(), 1);
        // Reset while waiting on the core: no fresh start pulse, result cleared.
        do_cmd(CMD_W'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if ({core_start, leds} !== 5'b0_0000 || fpga_to_arm_data !== '0) begin
                n_fail++;
                $display("FAIL reset_in_wait[%0d]: start,leds=%b data=..%h required 00000 0",
                         c, {core_start, leds}, fpga_to_arm_data[127:0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [CMD_W-1:0] c;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0, 1: op_read(rand_word(), $urandom_range(0, 2));
                2: begin
                    if ($urandom_range(0, 1) == 0) op_compute(rand_word(), $urandom_range(0, 1) == 1);
                    else op_write($urandom_range(0, 3));
                end
                default: begin
                    c = $urandom;
                    if (c < 3) c = 3;
                    op_bad(c);
                end
            endcase
        end
    endtask

    initial begin
        reset                  = 1'b1;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_done              = 1'b0;
        core_result            = '0;
        model_reset();

        test_reset();
        test_reads();
        test_compute_write();
        test_bad_cmd();
        test_abuse();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
